// File: rtl/tcdm_bank_pipe.sv
// TCDM bank array with a real response path: fixed-latency SRAM pipeline per bank,
// fall-through response FIFO and credit-based grant so responses can be back-pressured.

module tcdm_bank_pipe_bank #(
    parameter int BankSize  = 256,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int IdWidth   = 1,
    parameter int Latency   = 1,
    parameter int RespDepth = Latency + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req,
    output logic                   gnt,
    input  logic [AddrWidth-1:0]   add,
    input  logic                   wen,
    input  logic [DataWidth-1:0]   data,
    input  logic [DataWidth/8-1:0] be,
    input  logic [IdWidth-1:0]     id,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [DataWidth-1:0]   r_data,
    output logic [IdWidth-1:0]     r_id
);
    localparam int WordBits = $clog2(BankSize);
    localparam int CntW     = $clog2(RespDepth + 1);
    localparam int PtrW     = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
    } resp_t;

    logic [DataWidth-1:0] mem [BankSize];
    logic [WordBits-1:0]  widx;
    logic                 unused_add;
    logic                 accept, pop, fifo_push, fifo_pop, fifo_empty;
    logic [CntW-1:0]      cnt, fill;
    logic [PtrW-1:0]      rd_ptr, wr_ptr;
    logic [Latency:0]     vld_pipe;
    logic [Latency:1]     wen_pipe;
    logic [DataWidth-1:0] dat_pipe [Latency:1];
    logic [IdWidth-1:0]   id_pipe  [Latency:1];
    resp_t                fifo [RespDepth];
    resp_t                exit_rsp, head;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign widx       = add[WordBits+1:2];
    assign unused_add = ^{add[AddrWidth-1:WordBits+2], add[1:0]};

    // Credits cover in-flight plus queued responses, so a grant always has a FIFO slot.
    assign pop         = r_valid & r_ready;
    assign gnt         = (cnt < CntW'(RespDepth)) | ((cnt == CntW'(RespDepth)) & pop);
    assign accept      = req & gnt;
    assign vld_pipe[0] = accept;

    // SRAM macro model plus the data/id/wen side of the in-flight pipeline.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            dat_pipe[1] <= mem[widx];
            if (!wen) begin
                for (int b = 0; b < DataWidth / 8; b++)
                    if (be[b]) mem[widx][8*b +: 8] <= data[8*b +: 8];
            end
        end
        wen_pipe[1] <= wen;
        id_pipe[1]  <= id;
        for (int i = 2; i <= Latency; i++) begin
            dat_pipe[i] <= dat_pipe[i-1];
            wen_pipe[i] <= wen_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
        end
    end

    assign exit_rsp.data = wen_pipe[Latency] ? dat_pipe[Latency] : '0;
    assign exit_rsp.id   = id_pipe[Latency];

    // Fall-through: an exiting entry bypasses an empty FIFO and is not stored if popped at once.
    assign fifo_empty = (fill == '0);
    assign fifo_pop   = pop & ~fifo_empty;
    assign fifo_push  = vld_pipe[Latency] & ~(fifo_empty & pop);
    assign head       = fifo_empty ? exit_rsp : fifo[rd_ptr];
    assign r_valid    = ~fifo_empty | vld_pipe[Latency];
    assign r_data     = r_valid ? head.data : '0;
    assign r_id       = r_valid ? head.id : '0;

    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo[wr_ptr] <= exit_rsp;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe[Latency:1] <= '0;
            cnt                 <= '0;
            fill                <= '0;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
        end else begin
            vld_pipe[Latency:1] <= vld_pipe[Latency-1:0];
            cnt                 <= cnt + CntW'(accept) - CntW'(pop);
            fill                <= fill + CntW'(fifo_push) - CntW'(fifo_pop);
            if (fifo_push) wr_ptr <= ptr_next(wr_ptr);
            if (fifo_pop)  rd_ptr <= ptr_next(rd_ptr);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fifo_push && !fifo_pop && fill == CntW'(RespDepth)));

endmodule

module tcdm_bank_pipe #(
    parameter int NbBanks   = 16,
    parameter int BankSize  = 256,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int IdWidth   = 1,
    parameter int Latency   = 1,
    parameter int RespDepth = Latency + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NbBanks-1:0]                  req_i,
    output logic [NbBanks-1:0]                  gnt_o,
    input  logic [NbBanks-1:0][AddrWidth-1:0]   add_i,
    input  logic [NbBanks-1:0]                  wen_i,
    input  logic [NbBanks-1:0][DataWidth-1:0]   data_i,
    input  logic [NbBanks-1:0][DataWidth/8-1:0] be_i,
    input  logic [NbBanks-1:0][IdWidth-1:0]     id_i,
    output logic [NbBanks-1:0]                  r_valid_o,
    input  logic [NbBanks-1:0]                  r_ready_i,
    output logic [NbBanks-1:0][DataWidth-1:0]   r_data_o,
    output logic [NbBanks-1:0][IdWidth-1:0]     r_id_o
);
    for (genvar b = 0; b < NbBanks; b++) begin : g_bank
        tcdm_bank_pipe_bank #(
            .BankSize (BankSize),
            .DataWidth(DataWidth),
            .AddrWidth(AddrWidth),
            .IdWidth  (IdWidth),
            .Latency  (Latency),
            .RespDepth(RespDepth)
        ) u_bank (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req    (req_i[b]),
            .gnt    (gnt_o[b]),
            .add    (add_i[b]),
            .wen    (wen_i[b]),
            .data   (data_i[b]),
            .be     (be_i[b]),
            .id     (id_i[b]),
            .r_valid(r_valid_o[b]),
            .r_ready(r_ready_i[b]),
            .r_data (r_data_o[b]),
            .r_id   (r_id_o[b])
        );
    end

endmodule

// File: tb/tb_tcdm_bank_pipe.sv
// Directed bench: three instances (Latency 2/depth 3, Latency 1/depth 2, Latency 4/depth 5)
// share one stimulus bus; each scenario checks the instance whose configuration it targets.

module tb_tcdm_bank_pipe;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NB-1:0]        req, wen, rdy;
    logic [NB-1:0][31:0]  add, wdat;
    logic [NB-1:0][3:0]   be;
    logic [NB-1:0][0:0]   id;

    logic [NB-1:0]        gnt_a, rv_a, gnt_b, rv_b, gnt_c, rv_c;
    logic [NB-1:0][31:0]  rd_a, rd_b, rd_c;
    logic [NB-1:0][0:0]   ri_a, ri_b, ri_c;

    int errs = 0;
    int checks = 0;

    tcdm_bank_pipe #(.NbBanks(NB), .BankSize(256), .DataWidth(32), .AddrWidth(32), .IdWidth(1),
                     .Latency(2), .RespDepth(3)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_a), .add_i(add), .wen_i(wen),
        .data_i(wdat), .be_i(be), .id_i(id), .r_valid_o(rv_a), .r_ready_i(rdy),
        .r_data_o(rd_a), .r_id_o(ri_a));

    tcdm_bank_pipe #(.NbBanks(NB), .BankSize(256), .DataWidth(32), .AddrWidth(32), .IdWidth(1),
                     .Latency(1), .RespDepth(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_b), .add_i(add), .wen_i(wen),
        .data_i(wdat), .be_i(be), .id_i(id), .r_valid_o(rv_b), .r_ready_i(rdy),
        .r_data_o(rd_b), .r_id_o(ri_b));

    tcdm_bank_pipe #(.NbBanks(NB), .BankSize(256), .DataWidth(32), .AddrWidth(32), .IdWidth(1),
                     .Latency(4), .RespDepth(5)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_c), .add_i(add), .wen_i(wen),
        .data_i(wdat), .be_i(be), .id_i(id), .r_valid_o(rv_c), .r_ready_i(rdy),
        .r_data_o(rd_c), .r_id_o(ri_c));

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        req  = '0;
        wen  = '1;
        add  = '0;
        wdat = '0;
        be   = '0;
        id   = '0;
    endtask

    task automatic drv(input int b, input logic rd, input int word, input logic [31:0] d,
                       input logic [3:0] bee, input logic i);
        req       = '0;
        req[b]    = 1'b1;
        wen[b]    = rd;
        add[b]    = 32'(word << 2);
        wdat[b]   = d;
        be[b]     = bee;
        id[b]     = i;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        rdy = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        smp();
        checks++;
        if ({rv_a, rv_b, rv_c} !== '0) begin
            errs++; $display("FAIL rst_valid: got %h want 0", {rv_a, rv_b, rv_c});
        end
        checks++;
        if ({gnt_a, gnt_b, gnt_c} !== '1) begin
            errs++; $display("FAIL rst_gnt: got %h want all ones", {gnt_a, gnt_b, gnt_c});
        end
        checks++;
        if ({rd_a, ri_a, rd_b, ri_b, rd_c, ri_c} !== '0) begin
            errs++; $display("FAIL rst_data_id: got nonzero, want 0");
        end
        nxt();
    endtask

    task automatic test_single_read();
        rdy = '1;
        drv(3, 1'b0, 5, 32'hDEADBEEF, 4'hF, 1'b0);
        smp();
        checks++;
        if (gnt_a[3] !== 1'b1) begin
            errs++; $display("FAIL sr_gnt_wr: got %b want 1", gnt_a[3]);
        end
        nxt();
        drv(3, 1'b1, 5, 32'h0, 4'hF, 1'b1);
        smp();
        checks++;
        if ({gnt_a[3], rv_a[3]} !== 2'b10) begin
            errs++; $display("FAIL sr_gnt_rd: got gnt/valid %b want 10", {gnt_a[3], rv_a[3]});
        end
        nxt();
        idle();
        smp();
        checks++;
        if ({rv_a[3], rd_a[3], ri_a[3]} !== {1'b1, 32'h0, 1'b0}) begin
            errs++; $display("FAIL sr_wr_resp: got v=%b d=%h id=%b want v=1 d=0 id=0",
                             rv_a[3], rd_a[3], ri_a[3]);
        end
        nxt();
        smp();
        checks++;
        if ({rv_a[3], rd_a[3], ri_a[3]} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
            errs++; $display("FAIL sr_rd_resp: got v=%b d=%h id=%b want v=1 d=deadbeef id=1",
                             rv_a[3], rd_a[3], ri_a[3]);
        end
        nxt();
        smp();
        checks++;
        if (rv_a[3] !== 1'b0) begin
            errs++; $display("FAIL sr_idle: got valid %b want 0", rv_a[3]);
        end
        nxt();
    endtask

    // Read issued the cycle right after the masked write also covers read-after-write.
    task automatic test_byte_enable();
        rdy = '1;
        drv(3, 1'b0, 6, 32'hFFFFFFFF, 4'hF, 1'b0);
        nxt();
        drv(3, 1'b0, 6, 32'h00000000, 4'b0101, 1'b0);
        nxt();
        drv(3, 1'b1, 6, 32'h0, 4'hF, 1'b1);
        nxt();
        idle();
        smp();
        nxt();
        smp();
        checks++;
        if ({rv_a[3], rd_a[3], ri_a[3]} !== {1'b1, 32'hFF00FF00, 1'b1}) begin
            errs++; $display("FAIL be_merge: got v=%b d=%h id=%b want v=1 d=ff00ff00 id=1",
                             rv_a[3], rd_a[3], ri_a[3]);
        end
        nxt();
    endtask

    task automatic test_back_pressure();
        int a;
        int ng;
        a  = 0;
        ng = 0;
        rdy = '1;
        for (int i = 0; i < 8; i++) begin
            drv(0, 1'b0, i, 32'h100 + 32'(i), 4'hF, 1'b0);
            nxt();
        end
        idle();
        do_reset();
        rdy = '0;
        for (int c = 0; c < 6; c++) begin
            drv(0, 1'b1, a, 32'h0, 4'hF, a[0]);
            smp();
            if (gnt_b[0]) begin
                ng++;
                a++;
            end
            nxt();
        end
        checks++;
        if (ng !== 2) begin
            errs++; $display("FAIL bp_grants: got %0d want 2", ng);
        end
        drv(0, 1'b1, a, 32'h0, 4'hF, a[0]);
        smp();
        checks++;
        if ({gnt_b[0], rv_b[0], rd_b[0]} !== {1'b0, 1'b1, 32'h100}) begin
            errs++; $display("FAIL bp_stalled: got g=%b v=%b d=%h want g=0 v=1 d=100",
                             gnt_b[0], rv_b[0], rd_b[0]);
        end
        nxt();
        rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv(0, 1'b1, a, 32'h0, 4'hF, a[0]);
            smp();
            checks++;
            if ({gnt_b[0], rv_b[0], rd_b[0]} !== {1'b1, 1'b1, 32'h100 + 32'(k)}) begin
                errs++; $display("FAIL bp_drain_k%0d: got g=%b v=%b d=%h want g=1 v=1 d=%h",
                                 k, gnt_b[0], rv_b[0], rd_b[0], 32'h100 + 32'(k));
            end
            if (gnt_b[0]) a++;
            nxt();
        end
        idle();
        for (int k = 4; k < 6; k++) begin
            smp();
            checks++;
            if ({rv_b[0], rd_b[0]} !== {1'b1, 32'h100 + 32'(k)}) begin
                errs++; $display("FAIL bp_tail_k%0d: got v=%b d=%h want v=1 d=%h",
                                 k, rv_b[0], rd_b[0], 32'h100 + 32'(k));
            end
            nxt();
        end
        smp();
        checks++;
        if (rv_b[0] !== 1'b0) begin
            errs++; $display("FAIL bp_empty: got valid %b want 0", rv_b[0]);
        end
        nxt();
    endtask

    task automatic test_throughput();
        rdy = '1;
        for (int i = 0; i < 64; i++) begin
            drv(1, 1'b0, i, 32'h1000 + 32'(i), 4'hF, 1'b0);
            nxt();
        end
        idle();
        do_reset();
        for (int c = 0; c < 68; c++) begin
            logic eb, ec;
            if (c < 64) drv(1, 1'b1, c, 32'h0, 4'hF, c[0]);
            else idle();
            smp();
            eb = (c >= 1) && (c <= 64);
            ec = (c >= 4) && (c <= 67);
            if (c < 64) begin
                checks++;
                if ({gnt_b[1], gnt_c[1]} !== 2'b11) begin
                    errs++; $display("FAIL tp_gnt_c%0d: got %b want 11", c, {gnt_b[1], gnt_c[1]});
                end
            end
            checks++;
            if ({rv_b[1], rv_c[1]} !== {eb, ec}) begin
                errs++; $display("FAIL tp_valid_c%0d: got %b want %b", c, {rv_b[1], rv_c[1]}, {eb, ec});
            end
            if (eb) begin
                checks++;
                if ({rd_b[1], ri_b[1]} !== {32'h1000 + 32'(c - 1), 1'(c - 1)}) begin
                    errs++; $display("FAIL tp_lat1_c%0d: got d=%h id=%b want d=%h",
                                     c, rd_b[1], ri_b[1], 32'h1000 + 32'(c - 1));
                end
            end
            if (ec) begin
                checks++;
                if ({rd_c[1], ri_c[1]} !== {32'h1000 + 32'(c - 4), 1'(c - 4)}) begin
                    errs++; $display("FAIL tp_lat4_c%0d: got d=%h id=%b want d=%h",
                                     c, rd_c[1], ri_c[1], 32'h1000 + 32'(c - 4));
                end
            end
            nxt();
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        rdy = '0;
        drv(2, 1'b0, 7, 32'hCAFE0007, 4'hF, 1'b0);
        nxt();
        drv(2, 1'b0, 8, 32'hCAFE0008, 4'hF, 1'b1);
        nxt();
        drv(2, 1'b1, 7, 32'h0, 4'hF, 1'b1);
        smp();
        checks++;
        if (gnt_a[2] !== 1'b1) begin
            errs++; $display("FAIL rp_gnt_third: got %b want 1", gnt_a[2]);
        end
        nxt();
        drv(2, 1'b1, 8, 32'h0, 4'hF, 1'b0);
        smp();
        checks++;
        if ({gnt_a[2], rv_a[2]} !== 2'b01) begin
            errs++; $display("FAIL rp_full: got gnt/valid %b want 01", {gnt_a[2], rv_a[2]});
        end
        nxt();
        idle();
        rst_n = 1'b0;
        #2;
        checks++;
        if (rv_a[2] !== 1'b0) begin
            errs++; $display("FAIL rp_async_clear: got valid %b want 0", rv_a[2]);
        end
        nxt();
        nxt();
        rst_n = 1'b1;
        rdy = '1;
        smp();
        checks++;
        if ({gnt_a[2], rv_a[2]} !== 2'b10) begin
            errs++; $display("FAIL rp_after: got gnt/valid %b want 10", {gnt_a[2], rv_a[2]});
        end
        nxt();
        for (int k = 0; k < 3; k++) begin
            smp();
            checks++;
            if (rv_a[2] !== 1'b0) begin
                errs++; $display("FAIL rp_no_ghost_%0d: got valid %b want 0", k, rv_a[2]);
            end
            nxt();
        end
        drv(2, 1'b1, 7, 32'h0, 4'hF, 1'b0);
        nxt();
        drv(2, 1'b1, 8, 32'h0, 4'hF, 1'b1);
        nxt();
        idle();
        smp();
        checks++;
        if ({rv_a[2], rd_a[2]} !== {1'b1, 32'hCAFE0007}) begin
            errs++; $display("FAIL rp_keep_w7: got v=%b d=%h want v=1 d=cafe0007", rv_a[2], rd_a[2]);
        end
        nxt();
        smp();
        checks++;
        if ({rv_a[2], rd_a[2]} !== {1'b1, 32'hCAFE0008}) begin
            errs++; $display("FAIL rp_keep_w8: got v=%b d=%h want v=1 d=cafe0008", rv_a[2], rd_a[2]);
        end
        nxt();
    endtask

    initial begin
        idle();
        rdy = '1;
        test_reset();
        test_single_read();
        test_byte_enable();
        test_back_pressure();
        test_throughput();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
